// File: rtl/apb_mvm_pkg.sv
// Shared constants for the APB matrix-vector accelerator: register map,
// CTRL/STATUS bit positions, FSM encodings and an index-width helper.
package apb_mvm_pkg;

  localparam logic [12:0] OFF_CTRL   = 13'h000;
  localparam logic [12:0] OFF_STATUS = 13'h004;
  localparam logic [12:0] OFF_A_DATA = 13'h008;
  localparam logic [12:0] OFF_X_DATA = 13'h00C;
  localparam logic [12:0] OFF_Y_BASE = 13'h100;

  localparam int CTRL_START  = 0;
  localparam int CTRL_CLEAR  = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Index width for an n-entry store; never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mvm_mac_core.sv
// Serial MAC engine: A/x stores, row/column walk, accumulator and Y file.
// One A[r][c]*x[c] product per RUN cycle; state is exported for observation.
module mvm_mac_core
  import apb_mvm_pkg::*;
#(
  parameter int DW   = 8,
  parameter int ROWS = 4,
  parameter int COLS = 16,
  parameter int AW   = 2*DW + $clog2(COLS) + 1,
  parameter int AIW  = idx_w(ROWS*COLS),
  parameter int CIW  = idx_w(COLS),
  parameter int RIW  = idx_w(ROWS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 clear,
  input  logic                 a_we,
  input  logic [AIW-1:0]       a_idx,
  input  logic                 x_we,
  input  logic [CIW-1:0]       x_idx,
  input  logic [DW-1:0]        wdata,
  input  logic [RIW-1:0]       y_idx,
  output logic signed [AW-1:0] y_rdata,
  output logic                 done_pulse,
  output logic [1:0]           state
);

  localparam logic [CIW-1:0] C_LAST = CIW'(COLS-1);
  localparam logic [RIW-1:0] R_LAST = RIW'(ROWS-1);

  logic signed [DW-1:0]   a_mem [ROWS*COLS];
  logic signed [DW-1:0]   x_mem [COLS];
  logic signed [AW-1:0]   y_mem [ROWS];
  logic [AIW-1:0]         a_ptr;
  logic [CIW-1:0]         c;
  logic [RIW-1:0]         r;
  logic signed [AW-1:0]   acc;
  logic signed [2*DW-1:0] prod;
  logic signed [AW-1:0]   sum;
  logic                   last_col;
  logic                   last_row;

  // a_ptr walks A row-major in lockstep with (r, c), avoiding an r*COLS multiply.
  assign prod     = a_mem[a_ptr] * x_mem[c];
  assign sum      = acc + AW'(prod);
  assign last_col = (c == C_LAST);
  assign last_row = (r == R_LAST);

  assign done_pulse = (state == ST_RUN) && last_col && last_row && !clear;
  assign y_rdata    = y_mem[y_idx];

  always_ff @(posedge clk) begin
    if (a_we) a_mem[a_idx] <= wdata;
    if (x_we) x_mem[x_idx] <= wdata;
    if ((state == ST_RUN) && last_col && !clear) y_mem[r] <= sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      a_ptr <= '0;
      c     <= '0;
      r     <= '0;
      acc   <= '0;
    end else if (clear) begin
      state <= ST_IDLE;
      a_ptr <= '0;
      c     <= '0;
      r     <= '0;
      acc   <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          a_ptr <= a_ptr + AIW'(1);
          if (last_col) begin
            acc <= '0;
            c   <= '0;
            r   <= r + RIW'(1);
            if (last_row) state <= ST_DONE;
          end else begin
            acc <= sum;
            c   <= c + CIW'(1);
          end
        end
        // IDLE and DONE both accept a start; DONE falls back to IDLE otherwise.
        default: begin
          if (start) begin
            state <= ST_RUN;
            a_ptr <= '0;
            c     <= '0;
            r     <= '0;
            acc   <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/apb_mvm_acc.sv
// APB slave wrapper for the matrix-vector accelerator: address decode,
// CTRL/STATUS registers, load counters, error reporting and interrupt.
module apb_mvm_acc
  import apb_mvm_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 13,
  parameter int DW             = 8,
  parameter int ROWS           = 4,
  parameter int COLS           = 16,
  parameter int AW             = 2*DW + $clog2(COLS) + 1
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic                      irq
);

  if (AW > 32) begin : g_aw_too_wide
    $error("apb_mvm_acc: accumulator width AW exceeds 32 bits");
  end

  localparam int WAW = APB_ADDR_WIDTH - 2;
  localparam int ACW = $clog2(ROWS*COLS + 1);
  localparam int XCW = $clog2(COLS + 1);
  localparam int AIW = idx_w(ROWS*COLS);
  localparam int CIW = idx_w(COLS);
  localparam int RIW = idx_w(ROWS);
  localparam logic [ACW-1:0] A_FULL = ACW'(ROWS*COLS);
  localparam logic [XCW-1:0] X_FULL = XCW'(COLS);

  logic [WAW-1:0] waddr;
  logic [5:0]     y_i;
  logic           hit_ctrl, hit_status, hit_a, hit_x, hit_y, y_ok;
  logic           wr, rd, busy, a_full, x_full;
  logic           ctrl_wr, ctrl_clear, ctrl_start, start_busy, start_go, start_bad;
  logic           a_wr, a_we, a_ovf, x_wr, x_we, x_ovf;
  logic [ACW-1:0] a_cnt;
  logic [XCW-1:0] x_cnt;
  logic           done, err, irq_en;
  logic [1:0]     mac_state;
  logic           done_pulse;
  logic signed [AW-1:0] y_rdata;
  logic [31:0]    status_word;
  logic           unused_bits;

  assign unused_bits = &{1'b0, PADDR[1:0], PWDATA};

  assign waddr      = PADDR[APB_ADDR_WIDTH-1:2];
  assign y_i        = waddr[5:0];
  assign hit_ctrl   = (waddr == WAW'(OFF_CTRL >> 2));
  assign hit_status = (waddr == WAW'(OFF_STATUS >> 2));
  assign hit_a      = (waddr == WAW'(OFF_A_DATA >> 2));
  assign hit_x      = (waddr == WAW'(OFF_X_DATA >> 2));
  assign hit_y      = (waddr[WAW-1:6] == (WAW-6)'(OFF_Y_BASE >> 8));
  assign y_ok       = hit_y && ({1'b0, y_i} < 7'(ROWS));

  // An access is the PSEL&PENABLE cycle; PREADY is always 1, so every access
  // completes in that cycle and all register effects land on its clock edge.
  assign wr     = PSEL & PENABLE & PWRITE;
  assign rd     = PSEL & PENABLE & ~PWRITE;
  assign busy   = (mac_state == ST_RUN);
  assign a_full = (a_cnt == A_FULL);
  assign x_full = (x_cnt == X_FULL);

  // clear outranks start in the same CTRL write.
  assign ctrl_wr    = wr & hit_ctrl;
  assign ctrl_clear = ctrl_wr & PWDATA[CTRL_CLEAR];
  assign ctrl_start = ctrl_wr & PWDATA[CTRL_START] & ~PWDATA[CTRL_CLEAR];
  assign start_busy = ctrl_start & busy;
  assign start_go   = ctrl_start & ~busy & a_full & x_full;
  assign start_bad  = ctrl_start & ~busy & ~(a_full & x_full);

  assign a_wr  = wr & hit_a;
  assign a_we  = a_wr & ~busy & ~a_full;
  assign a_ovf = a_wr & ~busy & a_full;
  assign x_wr  = wr & hit_x;
  assign x_we  = x_wr & ~busy & ~x_full;
  assign x_ovf = x_wr & ~busy & x_full;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      a_cnt  <= '0;
      x_cnt  <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
      irq_en <= 1'b0;
    end else if (ctrl_clear) begin
      a_cnt  <= '0;
      x_cnt  <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
      irq_en <= PWDATA[CTRL_IRQ_EN];
    end else begin
      if (a_we) a_cnt <= a_cnt + ACW'(1);
      if (x_we) x_cnt <= x_cnt + XCW'(1);
      if (ctrl_wr && !start_busy) irq_en <= PWDATA[CTRL_IRQ_EN];
      if (start_go) done <= 1'b0;
      else if (done_pulse) done <= 1'b1;
      if (start_bad || a_ovf || x_ovf) err <= 1'b1;
    end
  end

  always_comb begin
    status_word            = '0;
    status_word[STAT_BUSY] = busy;
    status_word[STAT_DONE] = done;
    status_word[STAT_ERR]  = err;
    status_word[15:8]      = 8'(a_cnt);
    status_word[31:16]     = 16'(x_cnt);
  end

  always_comb begin
    PRDATA = '0;
    if (PSEL && !PWRITE) begin
      if (hit_ctrl)        PRDATA[CTRL_IRQ_EN] = irq_en;
      else if (hit_status) PRDATA = status_word;
      else if (y_ok)       PRDATA = 32'(y_rdata);
    end
  end

  always_comb begin
    PSLVERR = 1'b0;
    if (wr) begin
      if (hit_ctrl)   PSLVERR = start_busy;
      else if (hit_a) PSLVERR = busy | a_full;
      else if (hit_x) PSLVERR = busy | x_full;
      else            PSLVERR = 1'b1;
    end else if (rd) begin
      PSLVERR = ~(hit_ctrl | hit_status | y_ok);
    end
  end

  assign PREADY = 1'b1;
  assign irq    = done & irq_en;

  mvm_mac_core #(
    .DW   (DW),
    .ROWS (ROWS),
    .COLS (COLS),
    .AW   (AW)
  ) u_core (
    .clk        (HCLK),
    .rst_n      (HRESETn),
    .start      (start_go),
    .clear      (ctrl_clear),
    .a_we       (a_we),
    .a_idx      (a_cnt[AIW-1:0]),
    .x_we       (x_we),
    .x_idx      (x_cnt[CIW-1:0]),
    .wdata      (PWDATA[DW-1:0]),
    .y_idx      (y_i[RIW-1:0]),
    .y_rdata    (y_rdata),
    .done_pulse (done_pulse),
    .state      (mac_state)
  );

endmodule
